// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED1  = 1'b1
    } lock_state_e;

    // Number of bytes touched by an access of the given size (0 for the illegal encoding).
    function automatic logic [2:0] access_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_BYTE: n = 3'd1;
            SIZE_HALF: n = 3'd2;
            SIZE_WORD: n = 3'd4;
            default:   n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Combinational legality check for one memory access: size encoding,
// natural alignment and fit inside the MEM_SIZE-byte memory.
module dmem_access_check
    import dmem_pkg::*;
#(
    parameter int MEM_SIZE = 512
) (
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    output logic        legal
);

    logic [32:0] end_addr;
    logic        aligned;

    // The end address is computed one bit wider so addresses near 2^32 cannot wrap into range.
    always_comb begin
        end_addr = {1'b0, addr} + {30'd0, access_bytes(size)};
        case (size)
            SIZE_BYTE: aligned = 1'b1;
            SIZE_HALF: aligned = ~addr[0];
            SIZE_WORD: aligned = (addr[1:0] == 2'b00);
            default:   aligned = 1'b0;
        endcase
        legal = aligned && (end_addr <= 33'(MEM_SIZE));
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port 0 = core LSU, port 1 = debug/DMA loader (may lock for bounded bursts).
//
//   state    | meaning
//   UNLOCKED | round-robin between both ports
//   LOCKED1  | only port 1 may be granted; ends when m1_lock drops or after LOCK_MAX grants
//
// In LOCKED1 the grant stays restricted to port 1 for the cycle in which m1_lock
// is seen low; the state returns to UNLOCKED at the following edge.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_SIZE = 512,
    parameter int LOCK_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    input  logic        m1_lock,
    output logic        mem_write_en,
    output logic        mem_read_en,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_store_size,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    lock_state_e      lock_state;
    logic [CNT_W-1:0] lock_cnt;
    logic             rr_ptr;       // 0: port 0 wins a tie, 1: port 1 wins a tie
    logic             relock_blk;   // port 1 may not re-lock until port 0 is served

    logic             any_gnt;
    logic             sel_we;
    logic             sel_legal;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic [1:0]       sel_size;
    logic [31:0]      resp_data;

    logic [1:0]       rvalid_q;
    logic [1:0]       err_q;
    logic [31:0]      rdata0_q;
    logic [31:0]      rdata1_q;

    // Same-cycle grant: lock restricts to port 1, otherwise round-robin on contention.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!reset) begin
            if (lock_state == LOCKED1) begin
                m1_gnt = m1_req;
            end else if (m0_req && m1_req) begin
                m0_gnt = ~rr_ptr;
                m1_gnt = rr_ptr;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    assign any_gnt   = m0_gnt | m1_gnt;
    assign sel_we    = m1_gnt ? m1_we    : m0_we;
    assign sel_addr  = m1_gnt ? m1_addr  : m0_addr;
    assign sel_size  = m1_gnt ? m1_size  : m0_size;
    assign sel_wdata = m1_gnt ? m1_wdata : m0_wdata;

    dmem_access_check #(
        .MEM_SIZE (MEM_SIZE)
    ) u_check (
        .addr  (sel_addr),
        .size  (sel_size),
        .legal (sel_legal)
    );

    // Memory interface is driven only by a legal winner; everything else parks at zero.
    always_comb begin
        mem_write_en   = 1'b0;
        mem_read_en    = 1'b0;
        mem_addr       = 32'd0;
        mem_store_size = 2'b00;
        mem_write_data = 32'd0;
        if (any_gnt && sel_legal) begin
            mem_write_en   = sel_we;
            mem_read_en    = ~sel_we;
            mem_addr       = sel_addr;
            mem_store_size = sel_size;
            mem_write_data = sel_wdata;
        end
    end

    // Read data arrives as the aligned word; drop the bytes below the access address.
    assign resp_data = (any_gnt && sel_legal && !sel_we)
                       ? (mem_read_data >> {sel_addr[1:0], 3'b000}) : 32'd0;

    // Lock FSM, lock counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_state <= UNLOCKED;
            lock_cnt   <= '0;
            rr_ptr     <= 1'b0;
            relock_blk <= 1'b0;
        end else begin
            if (m0_gnt) begin
                rr_ptr     <= 1'b1;
                relock_blk <= 1'b0;
            end
            if (m1_gnt) begin
                rr_ptr <= 1'b0;
            end
            case (lock_state)
                UNLOCKED: begin
                    if (m1_gnt && m1_lock && !relock_blk) begin
                        if (LOCK_MAX > 1) begin
                            lock_state <= LOCKED1;
                            lock_cnt   <= CNT_W'(1);
                        end else begin
                            relock_blk <= m0_req;
                        end
                    end
                end
                LOCKED1: begin
                    if (!m1_lock) begin
                        lock_state <= UNLOCKED;
                        lock_cnt   <= '0;
                    end else if (m1_gnt) begin
                        if (lock_cnt == CNT_LAST) begin
                            lock_state <= UNLOCKED;
                            lock_cnt   <= '0;
                            rr_ptr     <= 1'b0;
                            relock_blk <= m0_req;
                        end else begin
                            lock_cnt <= lock_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    lock_state <= UNLOCKED;
                    lock_cnt   <= '0;
                end
            endcase
        end
    end

    // One-cycle registered response per grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            rvalid_q <= {m1_gnt, m0_gnt};
            err_q    <= {m1_gnt & ~sel_legal, m0_gnt & ~sel_legal};
            rdata0_q <= m0_gnt ? resp_data : 32'd0;
            rdata1_q <= m1_gnt ? resp_data : 32'd0;
        end
    end

    // A response still in flight when reset rises is dropped, not delivered.
    assign m0_rvalid = rvalid_q[0] & ~reset;
    assign m1_rvalid = rvalid_q[1] & ~reset;
    assign m0_err    = err_q[0] & ~reset;
    assign m1_err    = err_q[1] & ~reset;
    assign m0_rdata  = reset ? 32'd0 : rdata0_q;
    assign m1_rdata  = reset ? 32'd0 : rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level reference model and a byte-array memory.
module tb_dmem_arbiter;

    localparam int MEM_SIZE = 512;
    localparam int LOCK_MAX = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [1:0]  m0_size, m1_size;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_write_en, mem_read_en;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic [1:0]  mem_store_size;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_SIZE(MEM_SIZE), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_size(m0_size), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_size(m1_size), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .m1_lock(m1_lock),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_addr(mem_addr),
        .mem_store_size(mem_store_size), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    // Data memory stand-in: async aligned-word read, byte-lane write at the clock edge.
    logic [7:0] mem [MEM_SIZE];
    assign mem_read_data = {mem[{mem_addr[8:2], 2'b11}], mem[{mem_addr[8:2], 2'b10}],
                            mem[{mem_addr[8:2], 2'b01}], mem[{mem_addr[8:2], 2'b00}]};
    always @(posedge clk) begin
        if (mem_write_en)
            for (int i = 0; i < 4; i++)
                if (i < (1 << mem_store_size))
                    mem[mem_addr[8:0] + 9'(i)] <= mem_write_data[8*i +: 8];
    end

    // Reference model state
    logic [7:0]  shadow [MEM_SIZE];
    int          m_ptr, m_locked, m_cnt, m_blk;
    bit          p_v [2];
    bit          p_err [2];
    logic [31:0] p_data [2];
    bit          e_g0, e_g1, e_legal, e_wen, e_ren;
    bit          w_we;
    logic [31:0] w_addr, w_wdata;
    logic [1:0]  w_size;
    int          checks = 0;
    int          errors = 0;

    function automatic bit ref_legal(input logic [31:0] a, input logic [1:0] s);
        longint n, la;
        if (s == 2'b11) return 1'b0;
        n  = longint'(1) << s;
        la = longint'({32'd0, a});
        if (la % n != 0) return 1'b0;
        return (la + n) <= MEM_SIZE;
    endfunction

    // Bytes from the access address up to the end of its word, packed low-first.
    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] r;
        int base, off;
        r    = 32'd0;
        base = int'(a[8:0]);
        off  = base % 4;
        for (int i = 0; i < 4 - off; i++)
            r = r | (32'(shadow[base + i]) << (8 * i));
        return r;
    endfunction

    task automatic predict();
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (!reset) begin
            if (m_locked != 0) e_g1 = m1_req;
            else if (m0_req && m1_req) begin
                if (m_ptr == 0) e_g0 = 1'b1; else e_g1 = 1'b1;
            end else begin
                e_g0 = m0_req;
                e_g1 = m1_req;
            end
        end
        w_we    = e_g1 ? m1_we    : m0_we;
        w_addr  = e_g1 ? m1_addr  : m0_addr;
        w_size  = e_g1 ? m1_size  : m0_size;
        w_wdata = e_g1 ? m1_wdata : m0_wdata;
        e_legal = (e_g0 || e_g1) && ref_legal(w_addr, w_size);
        e_wen   = e_legal && w_we;
        e_ren   = e_legal && !w_we;
    endtask

    task automatic commit();
        if (reset) begin
            m_ptr = 0; m_locked = 0; m_cnt = 0; m_blk = 0;
            for (int p = 0; p < 2; p++) begin p_v[p] = 0; p_err[p] = 0; p_data[p] = 32'd0; end
        end else begin
            p_v[0] = e_g0; p_v[1] = e_g1;
            p_err[0] = e_g0 && !e_legal; p_err[1] = e_g1 && !e_legal;
            p_data[0] = (e_g0 && e_ren) ? ref_read(w_addr) : 32'd0;
            p_data[1] = (e_g1 && e_ren) ? ref_read(w_addr) : 32'd0;
            if (e_wen)
                for (int i = 0; i < (1 << w_size); i++)
                    shadow[int'(w_addr[8:0]) + i] = w_wdata[8*i +: 8];
            if (e_g0) begin m_ptr = 1; m_blk = 0; end
            if (e_g1) m_ptr = 0;
            if (m_locked != 0) begin
                if (!m1_lock) begin m_locked = 0; m_cnt = 0; end
                else if (e_g1) begin
                    m_cnt++;
                    if (m_cnt == LOCK_MAX) begin
                        m_locked = 0; m_cnt = 0; m_ptr = 0; m_blk = m0_req ? 1 : 0;
                    end
                end
            end else if (e_g1 && m1_lock && m_blk == 0) begin
                m_locked = 1; m_cnt = 1;
            end
        end
    endtask

    // Evaluate the model for the current inputs and move to the sampling point.
    task automatic settle();
        predict();
        @(negedge clk);
    endtask

    // Close the cycle: clock edge, model update, then inputs may change.
    task automatic advance();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_size = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_size = 0; m1_wdata = 0;
        m1_lock = 0;
    endtask

    task automatic set_m0(input bit we, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        m0_req = 1; m0_we = we; m0_addr = a; m0_size = s; m0_wdata = d;
    endtask

    task automatic set_m1(input bit we, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        m1_req = 1; m1_we = we; m1_addr = a; m1_size = s; m1_wdata = d;
    endtask

    task automatic test_reset();
        reset = 1;
        set_m0(0, 32'h10, 2'b10, 0);
        set_m1(1, 32'h20, 2'b10, 32'h1234);
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err} !== 6'b0) begin
                errors++; $display("FAIL reset_flags: got %b want 000000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err});
            end
            checks++;
            if ({mem_write_en, mem_read_en} !== 2'b00 || m0_rdata !== 0 || m1_rdata !== 0) begin
                errors++; $display("FAIL reset_mem: we=%b re=%b rd0=%h rd1=%h want all 0", mem_write_en, mem_read_en, m0_rdata, m1_rdata);
            end
            advance();
        end
        reset = 0;
        idle();
    endtask

    task automatic test_write_read();
        set_m0(1, 32'h10, 2'b10, 32'hDEADBEEF);
        settle();
        checks++;
        if (m0_gnt !== 1 || m1_gnt !== 0 || mem_write_en !== 1 || mem_addr !== 32'h10) begin
            errors++; $display("FAIL wr_grant: gnt0=%b gnt1=%b we=%b addr=%h want 1 0 1 00000010", m0_gnt, m1_gnt, mem_write_en, mem_addr);
        end
        advance();
        set_m0(0, 32'h10, 2'b10, 0);
        settle();
        checks++;
        if (m0_rvalid !== 1 || m0_err !== 0 || m0_rdata !== 0) begin
            errors++; $display("FAIL wr_resp: rvalid=%b err=%b rdata=%h want 1 0 0", m0_rvalid, m0_err, m0_rdata);
        end
        checks++;
        if (m0_gnt !== 1 || mem_read_en !== 1 || mem_write_en !== 0) begin
            errors++; $display("FAIL rd_grant: gnt0=%b re=%b we=%b want 1 1 0", m0_gnt, mem_read_en, mem_write_en);
        end
        advance();
        idle();
        settle();
        checks++;
        if (m0_rvalid !== 1 || m0_err !== 0 || m0_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_resp: rvalid=%b err=%b rdata=%h want 1 0 deadbeef", m0_rvalid, m0_err, m0_rdata);
        end
        advance();
    endtask

    task automatic test_byte_shift();
        logic [31:0] want [2];
        want[0] = 32'h00DEADBE;
        want[1] = 32'h0000DEAD;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) set_m0(0, 32'h11, 2'b00, 0); else set_m0(0, 32'h12, 2'b01, 0);
            settle();
            advance();
            idle();
            settle();
            checks++;
            if (m0_rvalid !== 1 || m0_rdata !== want[k]) begin
                errors++; $display("FAIL shift_rd%0d: rvalid=%b rdata=%h want 1 %h", k, m0_rvalid, m0_rdata, want[k]);
            end
            advance();
        end
    endtask

    task automatic test_round_robin();
        bit prev_g0;
        set_m0(0, 32'h0, 2'b10, 0);
        set_m1(0, 32'h4, 2'b10, 0);
        prev_g0 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            settle();
            checks++;
            if (m0_gnt !== e_g0 || m1_gnt !== e_g1 || (m0_gnt ^ m1_gnt) !== 1'b1) begin
                errors++; $display("FAIL rr_grant c%0d: gnt0=%b gnt1=%b want %b %b", c, m0_gnt, m1_gnt, e_g0, e_g1);
            end
            if (c > 0) begin
                checks++;
                if (m0_gnt === prev_g0) begin
                    errors++; $display("FAIL rr_alternate c%0d: gnt0=%b repeated", c, m0_gnt);
                end
                checks++;
                if (m0_rvalid !== prev_g0 || m1_rvalid !== !prev_g0 || m0_rdata !== p_data[0] || m1_rdata !== p_data[1]) begin
                    errors++; $display("FAIL rr_resp c%0d: rv0=%b rv1=%b rd0=%h rd1=%h want %b %b %h %h", c, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, prev_g0, !prev_g0, p_data[0], p_data[1]);
                end
            end
            prev_g0 = m0_gnt;
            advance();
        end
        idle();
        settle();
        advance();
    endtask

    task automatic test_lock();
        bit want_g1;
        set_m0(0, 32'h8, 2'b10, 0);
        settle();
        advance();
        set_m1(0, 32'h40, 2'b10, 0);
        m1_lock = 1;
        for (int k = 0; k < 11; k++) begin
            want_g1 = (k != LOCK_MAX);
            settle();
            checks++;
            if (m1_gnt !== want_g1 || m0_gnt !== !want_g1 || m1_gnt !== e_g1) begin
                errors++; $display("FAIL lock_seq k%0d: gnt0=%b gnt1=%b want %b %b", k, m0_gnt, m1_gnt, !want_g1, want_g1);
            end
            advance();
        end
        idle();
        settle();
        advance();
    endtask

    task automatic test_illegal();
        int          port [5] = '{0, 1, 0, 1, 0};
        bit          wr   [5] = '{0, 1, 0, 0, 0};
        logic [31:0] adr  [5] = '{32'h3, 32'h1FE, 32'h20, 32'hFFFF_FFFC, 32'h1FC};
        logic [1:0]  sz   [5] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b10};
        bit          bad  [5] = '{1, 1, 1, 1, 0};
        logic [7:0]  keep [4];
        for (int j = 0; j < 4; j++) keep[j] = mem[508 + j];
        for (int k = 0; k < 5; k++) begin
            if (port[k] == 0) set_m0(wr[k], adr[k], sz[k], 32'hA5A5_5A5A);
            else              set_m1(wr[k], adr[k], sz[k], 32'hA5A5_5A5A);
            settle();
            checks++;
            if ((port[k] == 0 ? m0_gnt : m1_gnt) !== 1'b1 || (mem_write_en | mem_read_en) !== !bad[k]) begin
                errors++; $display("FAIL illegal_gnt k%0d: gnt0=%b gnt1=%b we=%b re=%b want enable %b", k, m0_gnt, m1_gnt, mem_write_en, mem_read_en, !bad[k]);
            end
            advance();
            idle();
            settle();
            checks++;
            if ((port[k] == 0 ? m0_err : m1_err) !== bad[k] || (port[k] == 0 ? m0_rdata : m1_rdata) !== p_data[port[k]]
                || (bad[k] && p_data[port[k]] !== 0)) begin
                errors++; $display("FAIL illegal_resp k%0d: err0=%b err1=%b rd0=%h rd1=%h want err %b rdata %h", k, m0_err, m1_err, m0_rdata, m1_rdata, bad[k], p_data[port[k]]);
            end
            advance();
        end
        checks++;
        if ({mem[508], mem[509], mem[510], mem[511]} !== {keep[0], keep[1], keep[2], keep[3]}) begin
            errors++; $display("FAIL illegal_mem: got %h want %h", {mem[508], mem[509], mem[510], mem[511]}, {keep[0], keep[1], keep[2], keep[3]});
        end
    endtask

    task automatic test_reset_locked();
        set_m1(0, 32'h80, 2'b10, 0);
        m1_lock = 1;
        settle();
        advance();
        settle();
        advance();
        reset = 1;
        settle();
        checks++;
        if (m1_rvalid !== 0 || m1_gnt !== 0) begin
            errors++; $display("FAIL rst_lock_drop: rvalid1=%b gnt1=%b want 0 0", m1_rvalid, m1_gnt);
        end
        advance();
        reset = 0;
        m1_lock = 0;
        set_m0(0, 32'h84, 2'b10, 0);
        settle();
        checks++;
        if (m0_gnt !== 1 || m1_gnt !== 0 || m1_rvalid !== 0 || m0_rvalid !== 0) begin
            errors++; $display("FAIL rst_lock_after: gnt0=%b gnt1=%b rv0=%b rv1=%b want 1 0 0 0", m0_gnt, m1_gnt, m0_rvalid, m1_rvalid);
        end
        advance();
        idle();
        settle();
        advance();
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int p = 0; p < 2; p++) begin
                a = 32'($urandom_range(0, 520));
                if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
                if ($urandom_range(0, 40) == 0) a = $urandom;
                if (p == 0) begin
                    m0_req = ($urandom_range(0, 3) != 0); m0_we = $urandom_range(0, 1) == 1;
                    m0_addr = a; m0_size = 2'($urandom_range(0, 3)); m0_wdata = $urandom;
                end else begin
                    m1_req = ($urandom_range(0, 3) != 0); m1_we = $urandom_range(0, 1) == 1;
                    m1_addr = a; m1_size = 2'($urandom_range(0, 3)); m1_wdata = $urandom;
                end
            end
            m1_lock = ($urandom_range(0, 9) < 7);
            settle();
            checks++;
            if (m0_gnt !== e_g0 || m1_gnt !== e_g1) begin
                errors++; $display("FAIL rnd_gnt c%0d: gnt0=%b gnt1=%b want %b %b", c, m0_gnt, m1_gnt, e_g0, e_g1);
            end
            checks++;
            if (mem_write_en !== e_wen || mem_read_en !== e_ren) begin
                errors++; $display("FAIL rnd_en c%0d: we=%b re=%b want %b %b", c, mem_write_en, mem_read_en, e_wen, e_ren);
            end
            checks++;
            if (mem_addr !== (e_legal ? w_addr : 32'd0) || mem_write_data !== (e_legal ? w_wdata : 32'd0)) begin
                errors++; $display("FAIL rnd_bus c%0d: addr=%h wdata=%h want %h %h", c, mem_addr, mem_write_data, e_legal ? w_addr : 32'd0, e_legal ? w_wdata : 32'd0);
            end
            checks++;
            if (m0_rvalid !== (p_v[0] && !reset) || m1_rvalid !== (p_v[1] && !reset)
                || m0_err !== (p_err[0] && !reset) || m1_err !== (p_err[1] && !reset)) begin
                errors++; $display("FAIL rnd_resp c%0d: rv=%b%b err=%b%b want %b%b %b%b", c, m0_rvalid, m1_rvalid, m0_err, m1_err,
                                   p_v[0] && !reset, p_v[1] && !reset, p_err[0] && !reset, p_err[1] && !reset);
            end
            checks++;
            if (m0_rdata !== (reset ? 32'd0 : p_data[0]) || m1_rdata !== (reset ? 32'd0 : p_data[1])) begin
                errors++; $display("FAIL rnd_rdata c%0d: rd0=%h rd1=%h want %h %h", c, m0_rdata, m1_rdata, reset ? 32'd0 : p_data[0], reset ? 32'd0 : p_data[1]);
            end
            advance();
        end
        reset = 0;
        idle();
    endtask

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) begin
            mem[i]    = 8'($urandom);
            shadow[i] = mem[i];
        end
        m_ptr = 0; m_locked = 0; m_cnt = 0; m_blk = 0;
        for (int p = 0; p < 2; p++) begin p_v[p] = 0; p_err[p] = 0; p_data[p] = 32'd0; end
        idle();
        reset = 1;
        #1;
        test_reset();
        test_write_read();
        test_byte_shift();
        test_round_robin();
        test_lock();
        test_illegal();
        test_reset_locked();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
